md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide sequencer between the EX stage and the shared `mul`/`div` units. It accepts one HI/LO arithmetic op at a time and drives the multiplier operands and the divider start/annul handshake. It raises the EX stall request until the 64-bit result is captured, then holds that result until the downstream pipeline advances. A flush annuls any in-flight operation.

## Interface
Parameters:
- `MUL_LAT`, default 2: fixed multiplier latency in cycles, from stable operands to valid `mul_result`; legal range is 1–15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: exception/ERET flush; annuls the current op.
- `req_valid` in 1: EX holds a mult/multu/div/divu.
- `req_op` in 2: operation select; 00 mult, 01 multu, 10 div, 11 divu.
- `req_a` in 32: rs operand.
- `req_b` in 32: rt operand.
- `res_accept` in 1: the EX→MEM register loads this cycle (stall[3] is NoStop).
- `stallreq` out 1: stall request to the stall controller.
- `res_valid` out 1: `res_hi`/`res_lo` are valid.
- `res_hi` out 32: HI result.
- `res_lo` out 32: LO result.
- `mul_signed` out 1: signed multiply select.
- `mul_a` out 32: multiplier operand A.
- `mul_b` out 32: multiplier operand B.
- `mul_result` in 64: multiplier product.
- `div_start` out 1: divider start.
- `div_signed` out 1: signed divide select.
- `div_a` out 32: dividend.
- `div_b` out 32: divisor.
- `div_annul` out 1: divider cancel.
- `div_result` in 64: divider output, {remainder, quotient}.
- `div_ready` in 1: divider result ready.

## Operation
- The FSM has four states: IDLE, MUL_WAIT, DIV_WAIT, DONE.
- Operand register `op_r`, `a_r`, `b_r`:
  - Loads on acceptance.
  - `mul_a`/`div_a` = `a_r`; `mul_b`/`div_b` = `b_r`.
  - `mul_signed` = (`op_r`==00); `div_signed` = (`op_r`==10).
- IDLE:
  - `req_valid & ~flush` → accept.
  - `op[1]`=0 → MUL_WAIT, with 4-bit counter `cnt` ← `MUL_LAT`.
  - `op[1]`=1 → DIV_WAIT.
- MUL_WAIT:
  - `cnt` decrements each cycle.
  - When `cnt`==1, {`res_hi`,`res_lo`} ← `mul_result` and the FSM → DONE.
- DIV_WAIT:
  - `div_start` = ~`div_ready`.
  - When `div_ready`=1: `res_hi` ← `div_result[63:32]` (remainder), `res_lo` ← `div_result[31:0]` (quotient), and the FSM → DONE.
- DONE:
  - `res_valid`=1.
  - `res_accept`=1 → IDLE.
  - `res_accept`=0 → hold the state and the result.
  - `req_valid` is ignored here: it still reflects the completed instruction, so it must not re-issue.
- `stallreq` = (IDLE & `req_valid` & ~`flush`) | MUL_WAIT | DIV_WAIT.
- `flush` in any state:
  - Next state is IDLE and `res_valid` drops next cycle.
  - `stallreq` is forced to 0 in the same cycle.
  - If the state is DIV_WAIT, `div_annul`=1 for that one cycle and `div_start`=0.
- `flush` has priority over `rst`-free transitions, including completion in the same cycle; the result is discarded.
- Reset: state IDLE, `cnt`=0, all operand/result registers 0.
  - Every output is 0 except `mul_a`/`div_a`/`mul_b`/`div_b`, which follow the zeroed registers, i.e. 0.

## Timing
- Accept cycle is T0, in IDLE; `stallreq`=1 combinationally from `req_valid`.
- Multiply:
  - MUL_WAIT occupies T1..T`MUL_LAT`; operands are stable from T1.
  - DONE at T`MUL_LAT`+1; `stallreq` is low that cycle.
  - With the default: stall for 3 cycles, result valid at T3.
- Divide:
  - `div_start` rises at T1.
  - Done is the cycle after `div_ready` is sampled high.
- Back-to-back: the earliest next acceptance is the cycle after DONE & `res_accept`.
- There are no combinational paths from `mul_result`/`div_result` to outputs; results are always registered.

## Configuration
- `MD_DIV_ZERO_BYPASS_EN` defined:
  - A div/divu with `req_b`==0 goes IDLE → DONE directly.
  - `res_hi` = `req_a`, `res_lo` = 32'hFFFF_FFFF.
  - The stall lasts 1 cycle (T0 only) and `div_start` never asserts.
- `MD_DIV_ZERO_BYPASS_EN` undefined: a zero divisor is sent to the divider like any other operand.

## Test plan
- mult, a=32'hFFFF_FFFE (−2), b=3, `MUL_LAT`=2, `res_accept`=1 → `stallreq` high T0–T2; T3 `res_valid`=1, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; IDLE at T4.
- multu with the same operands → hi=32'h0000_0002, lo=32'hFFFF_FFFA.
- div, a=−7, b=2; model divider asserts `div_ready` at T34 → `div_start` T1–T33; T35 hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFD; `stallreq` low from T35.
- divu a=100, b=7 with `res_accept`=0 for 3 cycles after DONE → `res_valid` held with hi=2, lo=14; no second `div_start`; IDLE the cycle after `res_accept`=1.
- div in DIV_WAIT at T5 with `flush`=1 → `div_annul`=1 and `stallreq`=0 at T5; IDLE at T6; no `res_valid`; a new mult at T6 is accepted normally.
- With `MD_DIV_ZERO_BYPASS_EN`: divu a=9, b=0 → `stallreq` at T0 only; T1 hi=9, lo=32'hFFFF_FFFF; `div_start` never asserts. Without the macro: `div_start` asserts at T1.

Source files
------------

// File: rtl/md_if.sv
// md_if: EX request/result, multiplier and divider signals of the multiply/divide sequencer.
interface md_if;
  logic        flush;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        res_accept;
  logic        stallreq;
  logic        res_valid;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_annul;
  logic [63:0] div_result;
  logic        div_ready;
  modport master (
    input  flush, req_valid, req_op, req_a, req_b, res_accept, mul_result, div_result, div_ready,
    output stallreq, res_valid, res_hi, res_lo, mul_signed, mul_a, mul_b,
           div_start, div_signed, div_a, div_b, div_annul
  );
  modport slave (
    output flush, req_valid, req_op, req_a, req_b, res_accept, mul_result, div_result, div_ready,
    input  stallreq, res_valid, res_hi, res_lo, mul_signed, mul_a, mul_b,
           div_start, div_signed, div_a, div_b, div_annul
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide sequencer between EX and the shared mul/div units.
// Optional MD_DIV_ZERO_BYPASS_EN: divide by zero completes in IDLE without using the divider.
module md_sched #(
  parameter int MUL_LAT = 2
) (
  input logic clk,
  input logic rst,
  md_if.master m
);
  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [1:0] op_r;
  logic [31:0] a_r, b_r, hi_r, lo_r;
  logic accept, zero_div, mul_done, div_done;
  assign accept = state == IDLE && m.req_valid && !m.flush;
`ifdef MD_DIV_ZERO_BYPASS_EN
  assign zero_div = m.req_op[1] && m.req_b == 32'd0;
`else
  assign zero_div = 1'b0;
`endif
  assign mul_done = state == MUL_WAIT && cnt == 4'd1;
  assign div_done = state == DIV_WAIT && m.div_ready;
  always_comb begin
    state_n = state;
    if (m.flush) state_n = IDLE;
    else if (accept) state_n = !m.req_op[1] ? MUL_WAIT : zero_div ? DONE : DIV_WAIT;
    else if (mul_done || div_done) state_n = DONE;
    else if (state == DONE && m.res_accept) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      op_r  <= 2'b00;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
    end else begin
      state <= state_n;
      if (state == MUL_WAIT) cnt <= cnt - 4'd1;
      if (accept) begin
        op_r <= m.req_op;
        a_r  <= m.req_a;
        b_r  <= m.req_b;
        if (!m.req_op[1]) cnt <= 4'(MUL_LAT);
        if (zero_div) begin
          hi_r <= m.req_a;
          lo_r <= 32'hFFFF_FFFF;
        end
      end
      // a flush in the completion cycle discards the result
      if (!m.flush && mul_done) {hi_r, lo_r} <= m.mul_result;
      if (!m.flush && div_done) {hi_r, lo_r} <= m.div_result;
    end
  end
  assign m.stallreq   = !m.flush && ((state == IDLE && m.req_valid) || state == MUL_WAIT || state == DIV_WAIT);
  assign m.res_valid  = state == DONE;
  assign m.res_hi     = hi_r;
  assign m.res_lo     = lo_r;
  // gated so the zeroed op register does not look like a signed mult out of reset
  assign m.mul_signed = op_r == 2'b00 && state != IDLE;
  assign m.mul_a      = a_r;
  assign m.mul_b      = b_r;
  assign m.div_signed = op_r == 2'b10;
  assign m.div_a      = a_r;
  assign m.div_b      = b_r;
  assign m.div_start  = state == DIV_WAIT && !m.div_ready && !m.flush;
  assign m.div_annul  = state == DIV_WAIT && m.flush;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched (MUL_LAT=2).
module tb_md_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  md_if bus();
  md_sched #(.MUL_LAT(2)) dut (.clk(clk), .rst(rst), .m(bus));
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flush = 0; bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0;
    bus.res_accept = 0; bus.mul_result = JUNK; bus.div_result = JUNK; bus.div_ready = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    tick(); tick(); #1;
    checks++; if ({bus.stallreq, bus.res_valid} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b want=00", {bus.stallreq, bus.res_valid}); end
    checks++; if ({bus.res_hi, bus.res_lo} !== 64'd0) begin errors++; $display("FAIL reset_result got=%h want=0", {bus.res_hi, bus.res_lo}); end
    checks++; if ({bus.mul_signed, bus.div_signed, bus.div_start, bus.div_annul} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl got=%b want=0000", {bus.mul_signed, bus.div_signed, bus.div_start, bus.div_annul}); end
    checks++; if ({bus.mul_a, bus.mul_b, bus.div_a, bus.div_b} !== 128'd0) begin errors++; $display("FAIL reset_operands got=%h want=0", {bus.mul_a, bus.mul_b}); end
    rst = 0;
  endtask

  task automatic test_mul(input logic [1:0] op, input logic [63:0] prod, input logic sgn);
    tick();
    bus.req_valid = 1; bus.req_op = op; bus.req_a = 32'hFFFF_FFFE; bus.req_b = 32'd3; bus.res_accept = 1; bus.mul_result = JUNK; #1;
    checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL mul_t0_stall op=%0d got=%b want=1", op, bus.stallreq); end
    tick(); #1;
    checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL mul_t1_stall op=%0d got=%b want=1", op, bus.stallreq); end
    checks++; if (bus.mul_signed !== sgn) begin errors++; $display("FAIL mul_signed op=%0d got=%b want=%b", op, bus.mul_signed, sgn); end
    checks++; if ({bus.mul_a, bus.mul_b} !== {32'hFFFF_FFFE, 32'd3}) begin errors++; $display("FAIL mul_operands got=%h want=fffffffe00000003", {bus.mul_a, bus.mul_b}); end
    tick(); bus.mul_result = prod; #1;
    checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL mul_t2_stall op=%0d got=%b want=1", op, bus.stallreq); end
    tick(); bus.mul_result = JUNK; #1;
    checks++; if ({bus.stallreq, bus.res_valid} !== 2'b01) begin errors++; $display("FAIL mul_t3_flags got=%b want=01", {bus.stallreq, bus.res_valid}); end
    checks++; if ({bus.res_hi, bus.res_lo} !== prod) begin errors++; $display("FAIL mul_result op=%0d got=%h want=%h", op, {bus.res_hi, bus.res_lo}, prod); end
    tick(); bus.req_valid = 0; #1;
    checks++; if ({bus.stallreq, bus.res_valid} !== 2'b00) begin errors++; $display("FAIL mul_t4_idle got=%b want=00", {bus.stallreq, bus.res_valid}); end
  endtask

  task automatic test_div_signed;
    tick();
    bus.req_valid = 1; bus.req_op = 2'b10; bus.req_a = 32'hFFFF_FFF9; bus.req_b = 32'd2; bus.res_accept = 1; #1;
    checks++; if ({bus.stallreq, bus.div_start} !== 2'b10) begin errors++; $display("FAIL div_t0 got=%b want=10", {bus.stallreq, bus.div_start}); end
    for (int t = 1; t <= 33; t++) begin
      tick(); #1;
      checks++; if ({bus.stallreq, bus.div_start} !== 2'b11) begin errors++; $display("FAIL div_start_t%0d got=%b want=11", t, {bus.stallreq, bus.div_start}); end
      if (t == 1) begin
        checks++; if ({bus.div_signed, bus.div_a, bus.div_b} !== {1'b1, 32'hFFFF_FFF9, 32'd2}) begin errors++; $display("FAIL div_operands got=%h want=1fffffff900000002", {bus.div_signed, bus.div_a, bus.div_b}); end
      end
    end
    tick(); bus.div_ready = 1; bus.div_result = {32'hFFFF_FFFF, 32'hFFFF_FFFD}; #1;
    checks++; if ({bus.stallreq, bus.div_start} !== 2'b10) begin errors++; $display("FAIL div_t34 got=%b want=10", {bus.stallreq, bus.div_start}); end
    tick(); bus.div_ready = 0; bus.div_result = JUNK; #1;
    checks++; if ({bus.stallreq, bus.res_valid} !== 2'b01) begin errors++; $display("FAIL div_t35_flags got=%b want=01", {bus.stallreq, bus.res_valid}); end
    checks++; if ({bus.res_hi, bus.res_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_result got=%h want=fffffffffffffffd", {bus.res_hi, bus.res_lo}); end
    tick(); bus.req_valid = 0; #1;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL div_t36_idle got=%b want=0", bus.res_valid); end
  endtask

  task automatic test_div_hold;
    tick();
    bus.req_valid = 1; bus.req_op = 2'b11; bus.req_a = 32'd100; bus.req_b = 32'd7; bus.res_accept = 0; #1;
    tick(); tick();
    bus.div_ready = 1; bus.div_result = {32'd2, 32'd14};
    tick(); bus.div_ready = 0; bus.div_result = JUNK;
    for (int t = 4; t <= 6; t++) begin
      tick(); #1;
      checks++; if ({bus.res_valid, bus.stallreq, bus.div_start} !== 3'b100) begin errors++; $display("FAIL hold_flags_t%0d got=%b want=100", t, {bus.res_valid, bus.stallreq, bus.div_start}); end
      checks++; if ({bus.res_hi, bus.res_lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL hold_result_t%0d got=%h want=000000020000000e", t, {bus.res_hi, bus.res_lo}); end
    end
    tick(); bus.res_accept = 1; #1;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL hold_t7_valid got=%b want=1", bus.res_valid); end
    tick(); bus.req_valid = 0; #1;
    checks++; if ({bus.res_valid, bus.div_start} !== 2'b00) begin errors++; $display("FAIL hold_t8_idle got=%b want=00", {bus.res_valid, bus.div_start}); end
  endtask

  task automatic test_flush_div;
    tick();
    bus.req_valid = 1; bus.req_op = 2'b10; bus.req_a = 32'd20; bus.req_b = 32'd3; bus.res_accept = 1; #1;
    for (int t = 1; t <= 4; t++) begin
      tick(); #1;
      checks++; if ({bus.div_start, bus.div_annul} !== 2'b10) begin errors++; $display("FAIL flush_pre_t%0d got=%b want=10", t, {bus.div_start, bus.div_annul}); end
    end
    tick(); bus.flush = 1; #1;
    checks++; if ({bus.div_annul, bus.stallreq, bus.div_start} !== 3'b100) begin errors++; $display("FAIL flush_t5 got=%b want=100", {bus.div_annul, bus.stallreq, bus.div_start}); end
    tick(); bus.flush = 0; bus.req_op = 2'b00; bus.req_a = 32'd5; bus.req_b = 32'd6; bus.mul_result = 64'd30; #1;
    checks++; if ({bus.res_valid, bus.stallreq, bus.div_annul} !== 3'b010) begin errors++; $display("FAIL flush_t6 got=%b want=010", {bus.res_valid, bus.stallreq, bus.div_annul}); end
    tick(); #1;
    checks++; if ({bus.stallreq, bus.mul_a, bus.mul_b} !== {1'b1, 32'd5, 32'd6}) begin errors++; $display("FAIL flush_t7_mul got=%h want=10000000500000006", {bus.stallreq, bus.mul_a, bus.mul_b}); end
    tick(); tick(); #1;
    checks++; if ({bus.res_valid, bus.res_hi, bus.res_lo} !== {1'b1, 64'd30}) begin errors++; $display("FAIL flush_t9_result got=%h want=1000000000000001e", {bus.res_valid, bus.res_hi, bus.res_lo}); end
    tick(); bus.req_valid = 0; bus.mul_result = JUNK; #1;
  endtask

  task automatic test_flush_idle;
    tick();
    bus.req_valid = 1; bus.req_op = 2'b00; bus.flush = 1; #1;
    checks++; if (bus.stallreq !== 1'b0) begin errors++; $display("FAIL flush_idle_t0 got=%b want=0", bus.stallreq); end
    tick(); bus.req_valid = 0; bus.flush = 0; #1;
    checks++; if ({bus.stallreq, bus.res_valid} !== 2'b00) begin errors++; $display("FAIL flush_idle_t1 got=%b want=00", {bus.stallreq, bus.res_valid}); end
    tick(); tick(); tick();
  endtask

  task automatic test_div_zero;
    tick();
    bus.req_valid = 1; bus.req_op = 2'b11; bus.req_a = 32'd9; bus.req_b = 32'd0; bus.res_accept = 1; #1;
    checks++; if (bus.stallreq !== 1'b1) begin errors++; $display("FAIL dz_t0_stall got=%b want=1", bus.stallreq); end
`ifdef MD_DIV_ZERO_BYPASS_EN
    tick(); #1;
    checks++; if ({bus.res_valid, bus.stallreq, bus.div_start} !== 3'b100) begin errors++; $display("FAIL dz_t1_flags got=%b want=100", {bus.res_valid, bus.stallreq, bus.div_start}); end
    checks++; if ({bus.res_hi, bus.res_lo} !== {32'd9, 32'hFFFF_FFFF}) begin errors++; $display("FAIL dz_result got=%h want=00000009ffffffff", {bus.res_hi, bus.res_lo}); end
    tick(); bus.req_valid = 0; #1;
    checks++; if ({bus.res_valid, bus.div_start} !== 2'b00) begin errors++; $display("FAIL dz_t2_idle got=%b want=00", {bus.res_valid, bus.div_start}); end
`else
    tick(); #1;
    checks++; if ({bus.stallreq, bus.div_start} !== 2'b11) begin errors++; $display("FAIL dz_t1_start got=%b want=11", {bus.stallreq, bus.div_start}); end
    tick(); bus.flush = 1; #1;
    checks++; if (bus.div_annul !== 1'b1) begin errors++; $display("FAIL dz_t2_annul got=%b want=1", bus.div_annul); end
    tick(); bus.flush = 0; bus.req_valid = 0; #1;
    checks++; if ({bus.stallreq, bus.res_valid} !== 2'b00) begin errors++; $display("FAIL dz_t3_idle got=%b want=00", {bus.stallreq, bus.res_valid}); end
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_mul(2'b00, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
    test_mul(2'b01, 64'h0000_0002_FFFF_FFFA, 1'b0);
    test_div_signed();
    test_div_hold();
    test_flush_div();
    test_flush_idle();
    test_div_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
